// File: rtl/downstream_aligner_pkg.sv
// Shared types and byte-lane helpers for the downstream byte-lane aligner.
package downstream_aligner_pkg;

    localparam int unsigned ENTRY_W = 73;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10
    } state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
    } entry_t;

    // Lanes at or above o.
    function automatic logic [7:0] lo_mask(input logic [2:0] o);
        return 8'hFF << o;
    endfunction

    // Lanes at or below e.
    function automatic logic [7:0] hi_mask(input logic [2:0] e);
        return 8'hFF >> (3'd7 - e);
    endfunction

endpackage

// File: rtl/downstream_aligner_if.sv
// Producer/consumer signal bundle of the downstream aligner.
interface downstream_aligner_if;
    logic        start;
    logic [2:0]  start_offset;
    logic [15:0] start_length;
    logic [63:0] in_data;
    logic        in_data_en;
    logic        in_data_last;
    logic        stall;
    logic [63:0] out_data;
    logic [7:0]  out_be;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    modport master (
        output start, start_offset, start_length, in_data, in_data_en, in_data_last, out_ready,
        input  stall, out_data, out_be, out_last, out_valid, busy
    );

    modport slave (
        input  start, start_offset, start_length, in_data, in_data_en, in_data_last, out_ready,
        output stall, out_data, out_be, out_last, out_valid, busy
    );
endinterface

// File: rtl/downstream_aligner_fifo.sv
// Synchronous output FIFO; dout reads as zero while empty.
module aligner_fifo
    import downstream_aligner_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = ENTRY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     fill
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fill <= fill + 1'b1;
            else if (pop && !push) fill <= fill - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign empty = (fill == '0);
    assign full  = (fill == (AW+1)'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/downstream_aligner.sv
// Shifts unaligned 64-bit source words to the destination byte offset and
// queues {data, byte enables, last} for the bus write side.
module downstream_aligner
    import downstream_aligner_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    downstream_aligner_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    state_t      state, state_next;
    logic        start_q, first, stall_q, busy_int;
    logic [2:0]  off;
    logic [15:0] len;
    logic [63:0] residue;

    logic        rise, launch, accept, spill, word_final, push, pop, empty, full;
    logic [15:0] len_m1;
    logic [3:0]  spill_sum;
    logic [2:0]  end_lane;
    logic [63:0] aligned, residue_next;
    logic [7:0]  be;
    entry_t      push_entry, head;
    logic [AW:0] fill, fill_next;

    assign rise     = bus.start & ~start_q;
    assign launch   = (state == S_IDLE) & rise & (bus.start_length != '0);
    assign accept   = (state == S_RUN) & bus.in_data_en;
    assign len_m1   = len - 16'd1;
    assign spill_sum = {1'b0, off} + {1'b0, len_m1[2:0]} + 4'd1;
    assign spill    = spill_sum > 4'd8;
    assign end_lane = off + len_m1[2:0];
    assign word_final = bus.in_data_last & ~spill;

    assign aligned      = (bus.in_data << {off, 3'b000}) | residue;
    assign residue_next = (off == 3'd0) ? '0 : bus.in_data >> (7'd64 - {1'b0, off, 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (launch) state_next = S_RUN;
            S_RUN:   if (accept && bus.in_data_last) state_next = spill ? S_FLUSH : S_IDLE;
            S_FLUSH: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        push       = 1'b0;
        be         = 8'hFF;
        push_entry = '0;
        busy_int   = (state != S_IDLE);
        case (state)
            S_RUN: begin
                if (bus.in_data_en) begin
                    if (first)      be = be & lo_mask(off);
                    if (word_final) be = be & hi_mask(end_lane);
                    push       = 1'b1;
                    push_entry = '{data: aligned, be: be, last: word_final};
                end
            end
            S_FLUSH: begin
                push       = 1'b1;
                push_entry = '{data: residue, be: hi_mask(end_lane), last: 1'b1};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            off     <= '0;
            len     <= '0;
            first   <= 1'b0;
            residue <= '0;
            stall_q <= 1'b0;
        end else begin
            start_q <= bus.start;
            stall_q <= fill_next > (AW+1)'(DEPTH - 2);
            if (launch) begin
                off     <= bus.start_offset;
                len     <= bus.start_length;
                first   <= 1'b1;
                residue <= '0;
            end else if (accept) begin
                first   <= 1'b0;
                residue <= residue_next;
            end
        end
    end

    assign pop       = ~empty & bus.out_ready;
    // Stall looks at the fill this edge produces, so the producer sees it one cycle earlier.
    assign fill_next = fill + (AW+1)'(push) - (AW+1)'(pop);

    aligner_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .fill  (fill)
    );

    assign bus.stall     = stall_q;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = head.data;
    assign bus.out_be    = head.be;
    assign bus.out_last  = head.last;
    assign bus.busy      = busy_int;

endmodule

// File: doc/downstream_aligner.md
Name: downstream_aligner

Overview:
Byte-lane aligner between the downstream data/ack stage and the bus write interface. Takes unaligned 64-bit host data words and shifts them to the destination byte offset. Generates per-word byte enables, including the extra spill word when needed. Buffers results in a small FIFO and throttles the producer through a stall output.

Parameters:
DEPTH, 4, output FIFO depth in 64-bit words (power of two, >=4)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  transfer request level; acted on at its rising edge only
start_offset  in  3  destination address bits [2:0], sampled on start rising edge
start_length  in  16  transfer length in bytes, sampled on start rising edge
in_data  in  64  source word, byte lane i = bits 8i+7:8i, little-endian
in_data_en  in  1  in_data valid this cycle; must be accepted, no back-pressure
in_data_last  in  1  qualifies in_data_en; final source word of transfer
stall  out  1  producer must not assert in_data_en in the next accepted cycle
out_data  out  64  aligned word (FIFO head)
out_be  out  8  byte enables of out_data
out_last  out  1  head word is final word of transfer
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer pops head when out_valid & out_ready
busy  out  1  state != S_IDLE

Behaviour:
- Reset values: stall=0, out_valid=0, out_data=0, out_be=0, out_last=0, busy=0. FIFO is emptied, residue=0, state=S_IDLE, start edge register=0.
- Start: start_q registers start; the rising edge is start & ~start_q.
  - In S_IDLE, a rising edge with start_length!=0 latches o=start_offset and len=start_length, sets first=1, residue=0 and moves to S_RUN.
  - start_length==0 is ignored. The state stays S_IDLE.
  - Rising edges in any other state are ignored.
- Shift, combinational on an accepted word:
  - aligned = low 64 bits of (in_data << 8*o) | residue.
  - residue_next = in_data >> (64-8*o); residue_next = 0 when o=0.
- Spill: spill = (o + ((len-1) mod 8) + 1) > 8. end_lane = (o + len - 1) mod 8.
- Byte enables:
  - Base value is 8'hFF.
  - If first, AND with lanes >= o.
  - If the word is final, AND with lanes <= end_lane.
- S_RUN, on in_data_en:
  - Push {aligned, be, last} into the FIFO on the same clock edge, then clear first.
  - If in_data_last & ~spill: the word is final, last=1, go to S_IDLE.
  - If in_data_last & spill: last=0, go to S_FLUSH.
- S_FLUSH: push {residue, lanes<=end_lane, last=1} in one cycle, then go to S_IDLE. Any in_data_en during this cycle is ignored.
- In S_IDLE, in_data_en and in_data_last are ignored. This covers the producer's repeated en/last pulses while it waits for bus completion.
- Latency: out_valid rises 1 cycle after the accepted in_data_en (FIFO write edge), provided the FIFO was empty.
- stall = registered (fill_next > DEPTH-2). This reserves one slot for the in-flight word and one for the flush word.
- Simultaneous push and pop keeps fill unchanged. A push while full is a protocol violation: flag it with a simulation assertion. The RTL does not guard it.
- in_data_last terminates the transfer. len is used only for byte enables and the spill decision; no mismatch check is made.
- Reset mid-transfer aborts the transfer: FIFO contents and residue are discarded.

Decomposition:
- Shared package:
  - state encoding S_IDLE=2'b00, S_RUN=2'b01, S_FLUSH=2'b10
  - byte-mask functions lo_mask(o) (lanes>=o) and hi_mask(e) (lanes<=e)
  - FIFO entry width constant 73 (64+8+1)
- One sub-module: aligner_fifo. It is a synchronous DEPTH x 73 FIFO with push, pop, dout, empty and fill count; the top-level reads the registered fill to form stall.

Test Plan:
- o=0, len=16, words 0x1111..., 0x2222..., out_ready=1 -> two outputs, be FF/FF, last on second, no flush, busy drops after second push.
- o=3, len=8, word 0x0706050403020100 -> out1 data 0x0403020100xxxxxx, be F8, last=0. Then flush word 0x...070605, be 07, last=1.
- o=5, len=2, word 0x...BBAA -> single output, bytes AA/BB in lanes 5/6, be 60, last=1, no flush.
- DEPTH=4, out_ready=0, 4-word stream -> stall registered high once fill>2, producer holds. Release out_ready -> all words out in order, no loss, no overflow assertion.
- After a completed transfer, drive in_data_en=in_data_last=1 for 5 cycles in S_IDLE -> no FIFO pushes, out_valid stays 0.
- Assert rst_n=0 mid S_RUN with 2 words buffered -> out_valid=0, stall=0, busy=0 immediately. A new start then runs cleanly.
